// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment scanner.
package seg7_scan_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // All segments and the DP dark (active-low drive).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    // All anodes off (active-low drive).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F; entry [0] is the rightmost literal.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decode.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Straight table lookup; every nibble value has a glyph.
    always_comb begin
        seg = SEG7_LUT[hex];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display with
// frame-coherent input snapshot, per-digit decimal point and per-digit blink.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] disp_num,
    input  logic [3:0]  point,
    input  logic [3:0]  blink,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [1:0]         idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [15:0]        num_s_q,     num_s_d;
    logic [3:0]         pt_s_q,      pt_s_d;
    logic [3:0]         blink_s_q,   blink_s_d;
    logic [3:0]         an_q,        an_d;
    logic [7:0]         seg_q,       seg_d;

    logic               scan_wrap;
    logic               frame_end;
    logic [3:0]         digit_nib;
    logic [6:0]         digit_seg;

    // Nibble of the snapshot for the digit currently being scanned.
    always_comb begin
        digit_nib = num_s_q[{idx_q, 2'b00} +: 4];
    end

    hex_to_seg7 u_dec (
        .hex (digit_nib),
        .seg (digit_seg)
    );

    // Next-state for scan counter, digit index, blink timer, snapshot and output drive.
    always_comb begin
        scan_wrap     = (scan_cnt_q == SCAN_LAST);
        frame_end     = scan_wrap && (idx_q == 2'd3);

        scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d         = scan_wrap ? idx_q + 2'd1 : idx_q;

        blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

        // Inputs are only sampled as the frame rolls from digit 3 back to digit 0,
        // so a frame never mixes old and new values.
        num_s_d       = frame_end ? disp_num : num_s_q;
        pt_s_d        = frame_end ? point    : pt_s_q;
        blink_s_d     = frame_end ? blink    : blink_s_q;

        // Output drive is built from pre-edge state, giving one cycle of latency from idx.
        an_d          = AN_OFF;
        an_d[idx_q]   = 1'b0;
        seg_d         = {~pt_s_q[idx_q], digit_seg};
        if (blink_s_q[idx_q] && !blink_phase_q) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    // State registers with synchronous active-low reset; snapshot tracks inputs while held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_q    <= '0;
            idx_q         <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            num_s_q       <= disp_num;
            pt_s_q        <= point;
            blink_s_q     <= blink;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            num_s_q       <= num_s_d;
            pt_s_q        <= pt_s_d;
            blink_s_q     <= blink_s_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed self-checking bench for seg7_scan_display (SCAN_DIV=4, BLINK_DIV=32).
module tb_seg7_scan_display;

    logic        clk;
    logic        reset;
    logic [15:0] disp_num;
    logic [3:0]  point;
    logic [3:0]  blink;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;

    int checks;
    int errors;

    // Expected drive for disp_num=1234, point=0: digit0..digit3 show 4,3,2,1.
    logic [3:0] an_1234  [4];
    logic [7:0] seg_1234 [4];

    seg7_scan_display #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .disp_num (disp_num),
        .point    (point),
        .blink    (blink),
        .AN       (AN),
        .SEGMENT  (SEGMENT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for three edges with the given inputs, then release.
    task automatic do_reset(input logic [15:0] n, input logic [3:0] p, input logic [3:0] b);
        reset    = 1'b0;
        disp_num = n;
        point    = p;
        blink    = b;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        disp_num = 16'h1234;
        point    = 4'h0;
        blink    = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (AN !== 4'b1111) begin
                errors++;
                $display("FAIL reset_an cycle %0d: got %b expected 1111", i, AN);
            end
            checks++;
            if (SEGMENT !== 8'hFF) begin
                errors++;
                $display("FAIL reset_seg cycle %0d: got %h expected ff", i, SEGMENT);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_scan();
        do_reset(16'h1234, 4'h0, 4'h0);
        for (int e = 1; e <= 32; e++) begin
            int d;
            tick();
            d = ((e - 1) / 4) % 4;
            checks++;
            if (AN !== an_1234[d] || SEGMENT !== seg_1234[d]) begin
                errors++;
                $display("FAIL basic_scan edge %0d: got AN=%b SEG=%h expected AN=%b SEG=%h",
                         e, AN, SEGMENT, an_1234[d], seg_1234[d]);
            end
        end
    endtask

    task automatic test_decode_dp();
        logic [7:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg[0] = 8'h80; exp_seg[1] = 8'hC0; exp_seg[2] = 8'h0E; exp_seg[3] = 8'h88;
        exp_an[0]  = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        do_reset(16'hAF08, 4'b0100, 4'h0);
        for (int e = 1; e <= 16; e++) begin
            int d;
            tick();
            d = (e - 1) / 4;
            checks++;
            if (AN !== exp_an[d] || SEGMENT !== exp_seg[d]) begin
                errors++;
                $display("FAIL decode_dp edge %0d: got AN=%b SEG=%h expected AN=%b SEG=%h",
                         e, AN, SEGMENT, exp_an[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_frame_coherence();
        do_reset(16'h1234, 4'h0, 4'h0);
        repeat (5) tick();          // edge 5 shows digit1; idx is 1
        disp_num = 16'h5678;
        for (int e = 6; e <= 16; e++) begin
            int d;
            tick();
            d = (e - 1) / 4;
            checks++;
            if (AN !== an_1234[d] || SEGMENT !== seg_1234[d]) begin
                errors++;
                $display("FAIL frame_hold edge %0d: got AN=%b SEG=%h expected AN=%b SEG=%h",
                         e, AN, SEGMENT, an_1234[d], seg_1234[d]);
            end
        end
        tick();                     // edge 17: new frame, digit0 = 8
        checks++;
        if (AN !== 4'b1110 || SEGMENT !== 8'h80) begin
            errors++;
            $display("FAIL frame_new_d0: got AN=%b SEG=%h expected AN=1110 SEG=80", AN, SEGMENT);
        end
        repeat (4) tick();          // edge 21: digit1 = 7
        checks++;
        if (AN !== 4'b1101 || SEGMENT !== 8'hF8) begin
            errors++;
            $display("FAIL frame_new_d1: got AN=%b SEG=%h expected AN=1101 SEG=f8", AN, SEGMENT);
        end
    endtask

    task automatic test_blink();
        do_reset(16'h1234, 4'h0, 4'b0001);
        for (int e = 1; e <= 64; e++) begin
            int d;
            logic [3:0] ea;
            logic [7:0] es;
            tick();
            d  = ((e - 1) / 4) % 4;
            ea = an_1234[d];
            es = seg_1234[d];
            if (d == 0 && e > 32) begin
                ea = 4'b1111;
                es = 8'hFF;
            end
            checks++;
            if (AN !== ea || SEGMENT !== es) begin
                errors++;
                $display("FAIL blink edge %0d: got AN=%b SEG=%h expected AN=%b SEG=%h",
                         e, AN, SEGMENT, ea, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(16'h1234, 4'h0, 4'b0001);
        repeat (41) tick();         // blink phase now off; idx is 2
        checks++;
        if (AN !== 4'b1011 || SEGMENT !== 8'hA4) begin
            errors++;
            $display("FAIL reset_mid_pre: got AN=%b SEG=%h expected AN=1011 SEG=a4", AN, SEGMENT);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (AN !== 4'b1111 || SEGMENT !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_hold: got AN=%b SEG=%h expected AN=1111 SEG=ff", AN, SEGMENT);
        end
        reset = 1'b1;
        tick();                     // digit0 visible again: phase restored
        checks++;
        if (AN !== 4'b1110 || SEGMENT !== 8'h99) begin
            errors++;
            $display("FAIL reset_mid_restart: got AN=%b SEG=%h expected AN=1110 SEG=99", AN, SEGMENT);
        end
    endtask

    task automatic test_all_blink();
        do_reset(16'h1234, 4'b1111, 4'hF);
        repeat (32) tick();
        for (int e = 33; e <= 64; e++) begin
            tick();
            checks++;
            if (AN !== 4'b1111 || SEGMENT !== 8'hFF) begin
                errors++;
                $display("FAIL all_blink edge %0d: got AN=%b SEG=%h expected AN=1111 SEG=ff",
                         e, AN, SEGMENT);
            end
        end
        tick();                     // edge 65: visible again, digit0 with DP
        checks++;
        if (AN !== 4'b1110 || SEGMENT !== 8'h19) begin
            errors++;
            $display("FAIL all_blink_return: got AN=%b SEG=%h expected AN=1110 SEG=19", AN, SEGMENT);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        an_1234[0] = 4'b1110; seg_1234[0] = 8'h99;
        an_1234[1] = 4'b1101; seg_1234[1] = 8'hB0;
        an_1234[2] = 4'b1011; seg_1234[2] = 8'hA4;
        an_1234[3] = 4'b0111; seg_1234[3] = 8'hF9;
        reset    = 1'b0;
        disp_num = 16'h0;
        point    = 4'h0;
        blink    = 4'h0;

        test_reset();
        test_basic_scan();
        test_decode_dp();
        test_frame_coherence();
        test_blink();
        test_reset_mid();
        test_all_blink();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
